// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

    localparam int DEFAULT_IN_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_restore_step.sv
// One combinational restoring shift-subtract step: shifts the next dividend bit
// into the partial remainder and subtracts the divisor when it fits.
module div_restore_step #(
    parameter int IN_WIDTH = 32
) (
    input  logic [IN_WIDTH:0]   rem_in,
    input  logic                bit_in,
    input  logic [IN_WIDTH-1:0] divisor,
    output logic [IN_WIDTH:0]   rem_out,
    output logic                q_bit
);

    logic [IN_WIDTH+1:0] shifted;
    logic [IN_WIDTH+1:0] trial;

    // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
    always_comb begin
        shifted = {rem_in, bit_in};
        trial   = shifted - {2'b00, divisor};
        q_bit   = (shifted >= {2'b00, divisor});
        rem_out = q_bit ? trial[IN_WIDTH:0] : shifted[IN_WIDTH:0];
    end

endmodule

// File: rtl/iterative_divider.sv
// Iterative restoring divider: 2*IN_WIDTH / IN_WIDTH, one quotient bit per clock.
// Define DIV_OVERFLOW_CHECK_EN to detect d==0 / oversized quotients at start and finish immediately.
module iterative_divider
    import div_pkg::*;
#(
    parameter int IN_WIDTH = DEFAULT_IN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2*IN_WIDTH-1:0] n,
    input  logic [IN_WIDTH-1:0]   d,
    output logic                  busy,
    output logic                  done,
    output logic [IN_WIDTH-1:0]   q,
    output logic [IN_WIDTH-1:0]   r,
    output logic                  ovf
);

    localparam int CNT_W = $clog2(IN_WIDTH + 1);

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    count;
    logic [IN_WIDTH:0]   rem;
    logic [IN_WIDTH-1:0] shift;      // dividend low half shifts out, quotient bits shift in
    logic [IN_WIDTH-1:0] divisor;
    logic                accept;
    logic                last_step;
    logic                early_ovf;
    logic [IN_WIDTH:0]   step_rem;
    logic                step_q;

    assign accept    = start && (state == IDLE || state == DONE);
    assign last_step = (state == RUN) && (count == CNT_W'(1));

`ifdef DIV_OVERFLOW_CHECK_EN
    assign early_ovf = (d == '0) || (n[2*IN_WIDTH-1:IN_WIDTH] >= d);
`else
    assign early_ovf = 1'b0;
`endif

    div_restore_step #(.IN_WIDTH(IN_WIDTH)) u_step (
        .rem_in  (rem),
        .bit_in  (shift[IN_WIDTH-1]),
        .divisor (divisor),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // NOTE: reset is synchronous, so it is sampled only inside the clocked block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_next = early_ovf ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (accept) state_next = early_ovf ? DONE : RUN;
                else        state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            rem     <= '0;
            shift   <= '0;
            divisor <= '0;
        end else if (accept) begin
            count   <= CNT_W'(IN_WIDTH);
            rem     <= {1'b0, n[2*IN_WIDTH-1:IN_WIDTH]};
            shift   <= n[IN_WIDTH-1:0];
            divisor <= d;
        end else if (state == RUN) begin
            count   <= count - CNT_W'(1);
            rem     <= step_rem;
            shift   <= {shift[IN_WIDTH-2:0], step_q};
        end
    end

    // Results are loaded only at completion so they stay stable through the next run.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
            r <= '0;
        end else if (accept && early_ovf) begin
            q <= '1;
            r <= '0;
        end else if (last_step) begin
            q <= {shift[IN_WIDTH-2:0], step_q};
            r <= step_rem[IN_WIDTH-1:0];
        end
    end

`ifdef DIV_OVERFLOW_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (accept && early_ovf) begin
            ovf <= 1'b1;
        end else if (last_step) begin
            ovf <= 1'b0;
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_iterative_divider.sv
// Scoreboard bench for iterative_divider: the driver pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_iterative_divider;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2*W-1:0] n;
    logic [W-1:0]  d;
    logic          busy;
    logic          done;
    logic [W-1:0]  q;
    logic [W-1:0]  r;
    logic          ovf;

    always #5 clk = ~clk;

    iterative_divider #(.IN_WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .n     (n),
        .d     (d),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .r     (r),
        .ovf   (ovf)
    );

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         ovf;
        bit           chk_qr;
        string        name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   proto_err = 0;
    logic done_d    = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: compare every completed result against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            done_d = 1'b0;
        end else begin
            if (busy && done) proto_err++;
            if (done && done_d) proto_err++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done with q=0x%0h r=0x%0h, expected no result", q, r);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.chk_qr) begin
                        check({e.name, "_q"}, q, e.q);
                        check({e.name, "_r"}, r, e.r);
                    end
                    check({e.name, "_ovf"}, ovf, e.ovf);
                end
            end
            done_d = done;
        end
    end

    // Issue one start at the current negedge and wait (bounded) for its done.
    task automatic run_one(input string name, input logic [63:0] nn, input logic [W-1:0] dd,
                           input logic [W-1:0] eq, input logic [W-1:0] er, input logic eo,
                           input bit chk, output int cycles, output int busy_cycles);
        exp_t e;
        e = '{q: eq, r: er, ovf: eo, chk_qr: chk, name: name};
        start = 1'b1;
        n     = nn;
        d     = dd;
        exp_q.push_back(e);
        cycles      = 0;
        busy_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            start = 1'b0;
            cycles++;
            if (busy) busy_cycles++;
            if (done) break;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no done after %0d cycles, expected done", name, cycles);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int bcyc;
        int dones;
        int bad_int;
        logic [W-1:0] a, b, rm;
        logic [63:0]  nn;

        rst = 1'b1; start = 1'b0; n = '0; d = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_q", q, 0);
        check("reset_r", r, 0);
        check("reset_ovf", ovf, 0);

        // Basic division with latency and busy-width measurement.
        run_one("div_100_7", 64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1, cyc, bcyc);
        check("latency_100_7", cyc, 33);
        check("busy_cycles_100_7", bcyc, 32);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("q_held_after_done", q, 32'd14);
        check("r_held_after_done", r, 32'd2);

        run_one("div_max", 64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, cyc, bcyc);
        @(negedge clk);
        run_one("div_zero_n", 64'd0, 32'd5, 32'd0, 32'd0, 1'b0, 1'b1, cyc, bcyc);
        @(negedge clk);
        run_one("div_by_one", 64'h0000_0000_DEAD_BEEF, 32'd1, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1, cyc, bcyc);
        @(negedge clk);
        run_one("div_edge_fit", 64'h0000_0006_FFFF_FFFF, 32'd7, 32'hFFFF_FFFF, 32'd6, 1'b0, 1'b1, cyc, bcyc);
        @(negedge clk);

        // Start during RUN must be ignored.
        start = 1'b1; n = 64'd100; d = 32'd7;
        exp_q.push_back('{q: 32'd14, r: 32'd2, ovf: 1'b0, chk_qr: 1'b1, name: "ignored_start"});
        cyc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (cyc == 5) begin
                start = 1'b1; n = 64'd9; d = 32'd3;
            end
            if (done) break;
        end
        check("latency_ignored_start", cyc, 33);
        @(negedge clk);

        // Reset mid-RUN aborts with no done pulse.
        start = 1'b1; n = 64'd100; d = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("busy_before_abort", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_q", q, 0);
        check("abort_r", r, 0);
        rst = 1'b0;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("no_done_after_abort", dones, 0);
        run_one("div_50_5", 64'd50, 32'd5, 32'd10, 32'd0, 1'b0, 1'b1, cyc, bcyc);
        @(negedge clk);

`ifdef DIV_OVERFLOW_CHECK_EN
        run_one("div_by_zero", 64'd100, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1, cyc, bcyc);
        check("latency_div_by_zero", cyc, 1);
        check("busy_div_by_zero", bcyc, 0);
        @(negedge clk);
        run_one("ovf_hi_eq_d", 64'h0000_0005_0000_0000, 32'd5, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1, cyc, bcyc);
        check("latency_ovf_hi_eq_d", cyc, 1);
        @(negedge clk);
        run_one("after_ovf", 64'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b1, cyc, bcyc);
        @(negedge clk);
`else
        run_one("div_by_zero", 64'd100, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, cyc, bcyc);
        check("latency_div_by_zero", cyc, 33);
        @(negedge clk);
`endif

        // Back-to-back random operations: each start is issued in the DONE cycle.
        bad_int = 0;
        for (int k = 0; k < 200; k++) begin
            a  = $urandom;
            b  = $urandom | 32'd1;
            rm = $urandom % b;
            nn = {32'd0, a} * {32'd0, b} + {32'd0, rm};
            run_one("rand", nn, b, a, rm, 1'b0, 1'b1, cyc, bcyc);
            if (cyc != 33) bad_int++;
        end
        check("b2b_interval_errors", bad_int, 0);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        check("protocol_errors", proto_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
